// File: rtl/instr_sequencer.sv
// Instruction front-end: assembles little-endian instruction/payload bytes, issues one
// datapath command per instruction and reports a status byte per instruction.
module instr_sequencer #(
  parameter int BYTE_WIDTH     = 8,
  parameter int INSTR_BYTES    = 2,
  parameter int OPCODE_WIDTH   = 3,
  parameter int ADDRESS_SIZE   = 9,
  parameter int WORD_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STATUS_EN      = 1,
  localparam int INSTR_W = INSTR_BYTES * BYTE_WIDTH,
  localparam int DATA_W  = WORD_BYTES * BYTE_WIDTH,
  localparam int FLAG_W  = INSTR_W - OPCODE_WIDTH - ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_valid,
  input  logic [BYTE_WIDTH-1:0]   byte_data,
  output logic                    byte_ready,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [OPCODE_WIDTH-1:0] cmd_op,
  output logic [FLAG_W-1:0]       cmd_flags,
  output logic [ADDRESS_SIZE-1:0] cmd_addr,
  output logic [DATA_W-1:0]       cmd_data,
  input  logic                    cmd_done,
  input  logic                    cmd_err,
  output logic                    status_valid,
  input  logic                    status_ready,
  output logic [7:0]              status_data,
  output logic                    busy,
  output logic                    halted,
  output logic                    timeout_err
);

  if (FLAG_W < 1) begin : g_flag_chk
    $error("instr_sequencer: FLAG_W must be >= 1");
  end
  if (OPCODE_WIDTH < 3 || OPCODE_WIDTH > 6) begin : g_op_chk
    $error("instr_sequencer: OPCODE_WIDTH must be in 3..6");
  end

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MAXB  = (INSTR_BYTES > WORD_BYTES) ? INSTR_BYTES : WORD_BYTES;
  localparam int BC_W  = $clog2(MAXB + 1);

  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BC_W-1:0]  INSTR_LAST = BC_W'(INSTR_BYTES - 1);
  localparam logic [BC_W-1:0]  DATA_LAST  = BC_W'(WORD_BYTES - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

  typedef enum logic [2:0] {
    RESET_ST, GATHER_INSTR, GATHER_DATA, ISSUE, WAIT_DONE, REPORT, HALTED
  } state_t;

  state_t                    state;
  logic [INSTR_W-1:0]        instr_buf, instr_nx;
  logic [DATA_W-1:0]         data_buf, data_nx;
  logic [BC_W-1:0]           byte_cnt;
  logic [CNT_W-1:0]          gap_cnt, done_cnt;
  logic                      halt_pend;
  logic                      accept;
  logic [OPCODE_WIDTH-1:0]   nx_op;

  assign byte_ready = (state == GATHER_INSTR) || (state == GATHER_DATA);
  assign busy       = (state != GATHER_INSTR) && (state != RESET_ST);
  assign halted     = (state == HALTED);
  assign accept     = byte_valid && byte_ready;

  // Bytes shift in from the top so byte k ends at [k*BYTE_WIDTH +: BYTE_WIDTH].
  always_comb begin
    instr_nx = INSTR_W'({byte_data, instr_buf} >> BYTE_WIDTH);
    data_nx  = DATA_W'({byte_data, data_buf} >> BYTE_WIDTH);
    nx_op    = instr_nx[OPCODE_WIDTH-1:0];
  end

  function automatic logic [7:0] status_byte(input logic [1:0] code,
                                             input logic [OPCODE_WIDTH-1:0] op);
    return {code, 6'(op)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_ST;
      instr_buf    <= '0;
      data_buf     <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      done_cnt     <= '0;
      halt_pend    <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_flags    <= '0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      status_valid <= 1'b0;
      status_data  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        RESET_ST: state <= GATHER_INSTR;

        GATHER_INSTR: begin
          if (accept) begin
            gap_cnt <= '0;
            if (byte_cnt == INSTR_LAST) begin
              byte_cnt  <= '0;
              instr_buf <= '0;
              if (nx_op <= OP_LOAD) begin
                cmd_op    <= nx_op;
                cmd_flags <= instr_nx[OPCODE_WIDTH +: FLAG_W];
                cmd_addr  <= instr_nx[INSTR_W-1 -: ADDRESS_SIZE];
                cmd_data  <= '0;
                if (nx_op == OP_STORE) begin
                  state <= GATHER_DATA;
                end else begin
                  cmd_valid <= 1'b1;
                  state     <= ISSUE;
                end
              end else begin
                // NOP, HALT and illegal opcodes never reach the datapath.
                halt_pend <= (nx_op == OP_HALT);
                if (STATUS_EN != 0) begin
                  status_valid <= 1'b1;
                  status_data  <= status_byte((nx_op > OP_NOP) ? 2'b10 : 2'b00, nx_op);
                  state        <= REPORT;
                end else begin
                  state <= (nx_op == OP_HALT) ? HALTED : GATHER_INSTR;
                end
              end
            end else begin
              byte_cnt  <= byte_cnt + 1'b1;
              instr_buf <= instr_nx;
            end
          end else if (byte_cnt != '0) begin
            if (gap_cnt == GAP_LIMIT) begin
              byte_cnt  <= '0;
              instr_buf <= '0;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        GATHER_DATA: begin
          if (accept) begin
            gap_cnt <= '0;
            if (byte_cnt == DATA_LAST) begin
              byte_cnt  <= '0;
              data_buf  <= '0;
              cmd_data  <= data_nx;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              data_buf <= data_nx;
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            byte_cnt <= '0;
            data_buf <= '0;
            gap_cnt  <= '0;
            state    <= GATHER_INSTR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            done_cnt  <= '0;
            state     <= WAIT_DONE;
          end
        end

        // A done on the last allowed cycle wins over the timeout.
        WAIT_DONE: begin
          if (cmd_done || done_cnt == DONE_LAST) begin
            if (!cmd_done) timeout_err <= 1'b1;
            halt_pend <= 1'b0;
            if (STATUS_EN != 0) begin
              status_valid <= 1'b1;
              status_data  <= status_byte(cmd_done ? {1'b0, cmd_err} : 2'b11, cmd_op);
              state        <= REPORT;
            end else begin
              state <= GATHER_INSTR;
            end
          end else if (done_cnt != '1) begin
            done_cnt <= done_cnt + 1'b1;
          end
        end

        REPORT: begin
          if (status_ready) begin
            status_valid <= 1'b0;
            state        <= halt_pend ? HALTED : GATHER_INSTR;
          end
        end

        HALTED: state <= HALTED;

        default: state <= RESET_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised and directed bench for instr_sequencer; expectations come from the opcode
// and status rules applied to the generated instruction stream.
module tb_instr_sequencer;
  localparam int TO = 40;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        byte_ready;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_flags;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_done = 1'b0, cmd_err = 1'b0;
  logic        status_valid, status_ready = 1'b0;
  logic [7:0]  status_data;
  logic        busy, halted, timeout_err;

  instr_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_flags(cmd_flags),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .status_valid(status_valid), .status_ready(status_ready), .status_data(status_data),
    .busy(busy), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [45:0] all_outs = {byte_ready, cmd_valid, cmd_op, cmd_flags, cmd_addr, cmd_data,
                          status_valid, status_data, busy, halted, timeout_err};

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  flags;
    logic [8:0]  addr;
    logic [15:0] data;
  } cmd_t;

  cmd_t       cmd_obs[$];
  int         cmd_acc[$], cv_rise[$], st_rise[$], done_edge[$];
  logic [7:0] st_obs[$];
  bit         err_log[$];
  logic       cv_q = 1'b0, sv_q = 1'b0;

  // Edge indices: an event seen at a negedge happens at edge cyc+1; a rise seen there
  // was registered at edge cyc.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && !cv_q) cv_rise.push_back(cyc);
      if (cmd_valid && cmd_ready) begin
        cmd_obs.push_back({cmd_op, cmd_flags, cmd_addr, cmd_data});
        cmd_acc.push_back(cyc + 1);
      end
      if (status_valid && !sv_q) st_rise.push_back(cyc);
      if (status_valid && status_ready) st_obs.push_back(status_data);
      if (cmd_done) begin
        done_edge.push_back(cyc + 1);
        err_log.push_back(cmd_err);
      end
    end
    cv_q <= cmd_valid;
    sv_q <= status_valid;
  end

  bit dp_en = 1'b1, dp_hang = 1'b0, dp_rand = 1'b0, st_rand = 1'b0;
  int dp_dly = 1;

  // Datapath model: accepts commands and pulses done dp_dly cycles after acceptance.
  initial begin : responder
    bit last_v, pend, err_b;
    int wait_cnt;
    last_v = 1'b0; pend = 1'b0; err_b = 1'b0; wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      cmd_done = 1'b0;
      cmd_err  = 1'b0;
      if (!rst_n || !dp_en) begin
        cmd_ready = 1'b0;
        pend      = 1'b0;
      end else begin
        if (last_v && cmd_ready) begin
          pend     = !dp_hang;
          wait_cnt = dp_rand ? int'($urandom_range(1, 5)) : dp_dly;
          err_b    = dp_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        if (pend) begin
          if (wait_cnt <= 1) begin
            cmd_done = 1'b1;
            cmd_err  = err_b;
            pend     = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        cmd_ready = dp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      last_v = cmd_valid;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    status_ready = st_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic clear_logs();
    cmd_obs.delete(); cmd_acc.delete(); cv_rise.delete(); st_rise.delete();
    done_edge.delete(); st_obs.delete(); err_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        got = 1'b1;
        acc = cyc + 1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_byte_accept got=0 want=1 (byte %0h)", b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_st(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st_obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outs got=%0h want=0", all_outs); end
    rst_n = 1'b1;
    total++;
    if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_st_ready got=%b want=0", byte_ready); end
    idle(1);
    total++;
    if (byte_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_gather got=%b%b want=10", byte_ready, busy);
    end
  endtask

  task automatic test_fetch();
    int a; bit ok;
    clear_logs(); dp_dly = 3;
    send_byte(8'h21, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || cmd_obs.size() != 1 || cv_rise.size() != 1 || done_edge.size() != 1 || st_rise.size() != 1) begin
      bad++; $display("FAIL fetch_counts got=%0d want=1", cmd_obs.size());
    end else begin
      total++;
      if (cmd_obs[0] !== {3'd1, 4'h4, 9'h0, 16'h0}) begin
        bad++; $display("FAIL fetch_cmd got=%0h want=%0h", cmd_obs[0], {3'd1, 4'h4, 9'h0, 16'h0});
      end
      total++;
      if (cv_rise[0] != a) begin bad++; $display("FAIL fetch_latency got=%0d want=%0d", cv_rise[0], a); end
      total++;
      if (done_edge[0] != cmd_acc[0] + 3) begin
        bad++; $display("FAIL fetch_done_edge got=%0d want=%0d", done_edge[0], cmd_acc[0] + 3);
      end
      total++;
      if (st_obs[0] !== 8'h01) begin bad++; $display("FAIL fetch_status got=%0h want=01", st_obs[0]); end
      total++;
      if (st_rise[0] != done_edge[0]) begin
        bad++; $display("FAIL fetch_status_lat got=%0d want=%0d", st_rise[0], done_edge[0]);
      end
    end
  endtask

  task automatic test_store();
    int a; bit ok;
    clear_logs(); dp_dly = 2;
    send_byte(8'h10, a); send_byte(8'h00, a); send_byte(8'h34, a); send_byte(8'h12, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || cmd_obs.size() != 1 || cv_rise.size() != 1) begin
      bad++; $display("FAIL store_counts got=%0d want=1", cmd_obs.size());
    end else begin
      total++;
      if (cmd_obs[0] !== {3'd0, 4'h2, 9'h0, 16'h1234}) begin
        bad++; $display("FAIL store_cmd got=%0h want=%0h", cmd_obs[0], {3'd0, 4'h2, 9'h0, 16'h1234});
      end
      total++;
      if (cv_rise[0] != a) begin bad++; $display("FAIL store_latency got=%0d want=%0d", cv_rise[0], a); end
      total++;
      if (st_obs[0] !== 8'h00) begin bad++; $display("FAIL store_status got=%0h want=00", st_obs[0]); end
    end
  endtask

  task automatic test_illegal();
    int a; bit ok;
    clear_logs();
    send_byte(8'h07, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || st_obs[0] !== 8'h87) begin
      bad++; $display("FAIL illegal_status got=%0h want=87", ok ? st_obs[0] : 8'hxx);
    end
    total++;
    if (cmd_obs.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL illegal_no_cmd got=%0d/%b want=0/0", cmd_obs.size(), busy);
    end
  endtask

  task automatic test_timeout();
    int a; bit ok;
    clear_logs(); dp_hang = 1'b1;
    send_byte(8'h02, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    dp_hang = 1'b0;
    total++;
    if (!ok || st_rise.size() != 1 || cmd_acc.size() != 1) begin
      bad++; $display("FAIL timeout_counts got=%0d want=1", st_obs.size());
    end else begin
      total++;
      if (st_obs[0] !== 8'hC2) begin bad++; $display("FAIL timeout_status got=%0h want=c2", st_obs[0]); end
      total++;
      if (st_rise[0] != cmd_acc[0] + TO) begin
        bad++; $display("FAIL timeout_edge got=%0d want=%0d", st_rise[0], cmd_acc[0] + TO);
      end
    end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b want=1", timeout_err); end
    // Done on the last allowed cycle still counts as a completion.
    clear_logs(); dp_dly = TO;
    send_byte(8'h21, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || st_obs[0] !== 8'h01) begin
      bad++; $display("FAIL timeout_edge_done got=%0h want=01", ok ? st_obs[0] : 8'hxx);
    end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", timeout_err); end
    clear_logs(); dp_dly = TO + 1;
    send_byte(8'h21, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    idle(4);
    total++;
    if (!ok || st_obs.size() != 1 || st_obs[0] !== 8'hC1) begin
      bad++; $display("FAIL timeout_late_done got=%0h want=c1", ok ? st_obs[0] : 8'hxx);
    end
    dp_dly = 1;
  endtask

  task automatic test_resync();
    int a; bit ok;
    clear_logs(); dp_dly = 1;
    send_byte(8'h07, a);
    idle(TO + 5);
    send_byte(8'h05, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    idle(10);
    total++;
    if (!ok || st_obs.size() != 1 || st_obs[0] !== 8'h05) begin
      bad++; $display("FAIL resync_drop got=%0h/%0d want=05/1", ok ? st_obs[0] : 8'hxx, st_obs.size());
    end
    clear_logs();
    send_byte(8'h21, a);
    idle(TO - 5);
    send_byte(8'h00, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || cmd_obs.size() != 1 || st_obs[0] !== 8'h01) begin
      bad++; $display("FAIL resync_keep got=%0d want=1", cmd_obs.size());
    end
  endtask

  task automatic test_random();
    cmd_t exp_cmd[$];
    logic [2:0] ops[$];
    logic [2:0] op; logic [3:0] fl; logic [8:0] ad; logic [15:0] dt, ins;
    logic [1:0] code; logic [7:0] exp_st;
    int a, ei, pick; bit ok;
    clear_logs(); dp_rand = 1'b1; st_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 6);
      op = (pick >= 4) ? 3'(pick + 1) : 3'(pick);
      fl = 4'($urandom); ad = 9'($urandom); dt = 16'($urandom);
      ins = {ad, fl, op};
      send_byte(ins[7:0], a);
      idle($urandom_range(0, 3));
      send_byte(ins[15:8], a);
      if (op == 3'd0) begin
        idle($urandom_range(0, 3)); send_byte(dt[7:0], a);
        idle($urandom_range(0, 3)); send_byte(dt[15:8], a);
      end
      if (op <= 3'd3) exp_cmd.push_back({op, fl, ad, (op == 3'd0) ? dt : 16'h0});
      ops.push_back(op);
    end
    wait_st(ops.size(), 3000, ok);
    dp_rand = 1'b0; st_rand = 1'b0;
    total++;
    if (!ok || cmd_obs.size() != exp_cmd.size() || st_obs.size() != ops.size()) begin
      bad++; $display("FAIL rand_counts got=%0d/%0d want=%0d/%0d",
                      cmd_obs.size(), st_obs.size(), exp_cmd.size(), ops.size());
    end
    for (int i = 0; i < exp_cmd.size() && i < cmd_obs.size(); i++) begin
      total++;
      if (cmd_obs[i] !== exp_cmd[i]) begin
        bad++; $display("FAIL rand_cmd[%0d] got=%0h want=%0h", i, cmd_obs[i], exp_cmd[i]);
      end
    end
    ei = 0;
    for (int i = 0; i < ops.size() && i < st_obs.size(); i++) begin
      if (ops[i] <= 3'd3) begin
        code = (ei < err_log.size() && err_log[ei]) ? 2'b01 : 2'b00;
        ei++;
      end else begin
        code = (ops[i] > 3'd5) ? 2'b10 : 2'b00;
      end
      exp_st = {code, 3'b000, ops[i]};
      total++;
      if (st_obs[i] !== exp_st) begin
        bad++; $display("FAIL rand_status[%0d] got=%0h want=%0h", i, st_obs[i], exp_st);
      end
    end
  endtask

  task automatic test_halt();
    int a; bit ok, stuck;
    clear_logs();
    send_byte(8'h04, a); send_byte(8'h00, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || st_obs[0] !== 8'h04) begin
      bad++; $display("FAIL halt_status got=%0h want=04", ok ? st_obs[0] : 8'hxx);
    end
    byte_valid = 1'b1; byte_data = 8'h21;
    stuck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b1 || cmd_valid !== 1'b0) stuck = 1'b0;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    total++;
    if (!stuck) begin bad++; $display("FAIL halt_hold got=%b%b want=10", halted, byte_ready); end
  endtask

  task automatic test_reset_mid();
    int a; bit ok;
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    total++;
    if (halted !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_clear got=%b%b want=00", halted, timeout_err);
    end
    clear_logs(); dp_dly = 2;
    send_byte(8'h10, a); send_byte(8'h00, a); send_byte(8'h34, a);
    byte_valid = 1'b1; byte_data = 8'h12;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL mid_reset_outs got=%0h want=0", all_outs); end
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h10, a); send_byte(8'h00, a); send_byte(8'h78, a); send_byte(8'h56, a);
    wait_st(1, 400, ok);
    total++;
    if (!ok || cmd_obs.size() != 1 || st_obs.size() != 1) begin
      bad++; $display("FAIL mid_reset_counts got=%0d want=1", cmd_obs.size());
    end else begin
      total++;
      if (cmd_obs[0] !== {3'd0, 4'h2, 9'h0, 16'h5678} || st_obs[0] !== 8'h00) begin
        bad++; $display("FAIL mid_reset_store got=%0h/%0h want=%0h/00",
                        cmd_obs[0], st_obs[0], {3'd0, 4'h2, 9'h0, 16'h5678});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_illegal();
    test_timeout();
    test_resync();
    test_random();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
